mips_main_control: RTL and testbench
====================================

# mips_main_control

Multicycle MIPS main controller FSM. It sequences every instruction through fetch, decode, execute, memory and writeback. It drives the datapath enables and multiplexer selects, and produces the 2-bit `aluop` consumed by the ALU function decoder: 00 = add, 01 = subtract, 10 = decode `funct`. It sits beside the ALU decoder in the control path, takes `op` from the instruction register and `zero` from the ALU, and waits on a memory ready handshake.

## Interface
- No parameters.
- `clk` — in, 1 — single clock for the block; all state changes on its rising edge.
- `reset` — in, 1 — asynchronous, active-high.
- `op` — in, 6 — instr[31:26] from the instruction register; stable from DECODE until the return to FETCH.
- `zero` — in, 1 — ALU zero flag.
- `mem_ready` — in, 1 — memory access completes this cycle.
- `iord` — out, 1 — memory address select: 0 = PC, 1 = ALUOut.
- `memwrite` — out, 1 — memory write strobe.
- `irwrite` — out, 1 — instruction register load.
- `regdst` — out, 1 — register write destination: 1 = rd, 0 = rt.
- `memtoreg` — out, 1 — register write data: 1 = memory data, 0 = ALUOut.
- `regwrite` — out, 1 — register file write.
- `alusrca` — out, 1 — ALU A input: 0 = PC, 1 = register A.
- `alusrcb` — out, 2 — ALU B input: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `aluop` — out, 2 — to the ALU decoder.
- `pcsrc` — out, 2 — PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `pcen` — out, 1 — PC write enable (`pcwrite | taken branch`).
- `illegal` — out, 1 — one-cycle pulse in DECODE when `op` is unsupported.
- `retired` — out, 32 — count of completed instructions.

## Operation
- Opcodes:
  - lw = 100011, sw = 101011, R-type = 000000
  - beq = 000100, addi = 001000, j = 000010
  - bne = 000101 (macro only)
- State encoding (4 bits): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Encodings 12–15 return to FETCH on the next edge.
- Outputs are Moore decoded from state; `irwrite`/`pcen` in FETCH are also gated by `mem_ready`. Any output not listed for a state is 0.
- Per-state outputs and transitions:
  - **FETCH:** `alusrcb=01`, `aluop=00`, `pcsrc=00`. `irwrite = pcen = mem_ready`. Stays until `mem_ready` = 1, then goes to DECODE.
  - **DECODE:** `alusrcb=11`, `aluop=00` (branch target into ALUOut). Next state by `op`:
    - lw/sw → MEMADR
    - R-type → EXECUTE
    - beq → BRANCH
    - addi → ADDIEX
    - j → JUMP
    - other → FETCH with `illegal` = 1
  - **MEMADR:** `alusrca=1`, `alusrcb=10`, `aluop=00`. Goes to MEMRD for lw, MEMWR for sw.
  - **MEMRD:** `iord=1`. Holds until `mem_ready`, then goes to MEMWB.
  - **MEMWB:** `regwrite=1`, `memtoreg=1`, `regdst=0`, then FETCH.
  - **MEMWR:** `iord=1`, `memwrite=1`. Held until `mem_ready`, then FETCH.
  - **EXECUTE:** `alusrca=1`, `alusrcb=00`, `aluop=10`, then ALUWB.
  - **ALUWB:** `regwrite=1`, `regdst=1`, `memtoreg=0`, then FETCH.
  - **BRANCH:** `alusrca=1`, `alusrcb=00`, `aluop=01`, `pcsrc=01`, `pcen = zero`, then FETCH.
  - **ADDIEX:** `alusrca=1`, `alusrcb=10`, `aluop=00`, then ADDIWB.
  - **ADDIWB:** `regwrite=1`, `regdst=0`, `memtoreg=0`, then FETCH.
  - **JUMP:** `pcsrc=10`, `pcen=1`, then FETCH.
- `retired` increments by 1 on every transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP.
  - It does not increment on the illegal-opcode return or on a recovery from an unused encoding.
  - It wraps from 0xFFFFFFFF to 0.
- `illegal` is combinational in DECODE and lasts exactly one cycle.

## Timing
- Reset asserted, at any time including mid-instruction or mid-handshake:
  - state = FETCH immediately; `retired` = 0.
  - `irwrite`, `pcen`, `memwrite` and `regwrite` are forced to 0 while `reset` is high.
  - Other outputs take their FETCH values.
- Latency with `mem_ready` tied high: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.
- Each low cycle of `mem_ready` in FETCH, MEMRD or MEMWR adds exactly one cycle.
- `memwrite` stays high for every cycle of MEMWR, including the accepting cycle. No write occurs outside MEMWR.
- `pcen` is never asserted in the same cycle as `memwrite` or `regwrite`.

## Configuration
- `MAIN_CTRL_BNE_EN` defined:
  - bne (000101) decodes to BRANCH.
  - In BRANCH, `pcen = zero` for beq and `pcen = ~zero` for bne.
  - bne counts as retired.
- Undefined: 000101 is illegal, giving the DECODE → FETCH path with an `illegal` pulse.

## Test plan
- **Reset mid-lw:** reset asserted in MEMRD → same cycle `pcen`/`regwrite` = 0; after release, state FETCH and `retired` = 0.
- **lw with wait state:** lw, `mem_ready` low 2 cycles in MEMRD → 7 cycles total; `regwrite` = 1 with `memtoreg` = 1 only in the final cycle; `retired` 0 → 1.
- **R-type then beq:**
  - R-type → `aluop` = 10 in EXECUTE; `regdst` = 1 in ALUWB.
  - beq with `zero` = 1 → `aluop` = 01, `pcsrc` = 01, `pcen` = 1 in BRANCH.
  - beq with `zero` = 0 → `pcen` = 0.
- **sw and j:**
  - sw with `mem_ready` = 1 → `memwrite` high exactly one cycle, `iord` = 1.
  - j → `pcsrc` = 10, `pcen` = 1; `retired` advances by 2 in total.
- **Illegal opcode:** `op` = 111111 → `illegal` one cycle in DECODE, next state FETCH, `retired` unchanged. With `MAIN_CTRL_BNE_EN` and `op` = 000101, `zero` = 0 → `pcen` = 1.
- **Counter wrap:** force `retired` = 0xFFFFFFFF, run j → `retired` = 0.

Source files
------------

// File: rtl/mips_main_control.sv
`default_nettype none
// ============================================================================
// Module   : mips_main_control
// Purpose  : Main controller FSM for a multicycle MIPS datapath. It steps each
//            instruction through fetch, decode, execute, memory and writeback.
//            It drives datapath enables and mux selects, the 2-bit aluop for
//            the ALU function decoder, and counts retired instructions.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous, active-high
//   op         in   6   instr[31:26]; held stable from DECODE back to FETCH
//   zero       in   1   ALU zero flag
//   mem_ready  in   1   memory access completes this cycle
//   iord       out  1   memory address select (0 PC, 1 ALUOut)
//   memwrite   out  1   memory write strobe
//   irwrite    out  1   instruction register load
//   regdst     out  1   register destination (1 rd, 0 rt)
//   memtoreg   out  1   register write data (1 memory, 0 ALUOut)
//   regwrite   out  1   register file write
//   alusrca    out  1   ALU A select (0 PC, 1 reg A)
//   alusrcb    out  2   ALU B select (00 B, 01 4, 10 imm, 11 imm<<2)
//   aluop      out  2   00 add, 01 subtract, 10 decode funct
//   pcsrc      out  2   PC source (00 ALU, 01 ALUOut, 10 jump target)
//   pcen       out  1   PC write enable
//   illegal    out  1   one-cycle pulse in DECODE for an unsupported op
//   retired    out 32   completed instruction count (wraps)
// ----------------------------------------------------------------------------
// Build option
//   MAIN_CTRL_BNE_EN : when defined, bne (000101) is decoded as a branch
//                      taken on ~zero. When undefined, 000101 is illegal.
// ============================================================================
module mips_main_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        iord,
    output logic        memwrite,
    output logic        irwrite,
    output logic        regdst,
    output logic        memtoreg,
    output logic        regwrite,
    output logic        alusrca,
    output logic [1:0]  alusrcb,
    output logic [1:0]  aluop,
    output logic [1:0]  pcsrc,
    output logic        pcen,
    output logic        illegal,
    output logic [31:0] retired
);

    // Opcodes
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
`ifdef MAIN_CTRL_BNE_EN
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
`endif

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_retired;

    logic        w_iord;
    logic        w_memwrite;
    logic        w_irwrite;
    logic        w_regdst;
    logic        w_memtoreg;
    logic        w_regwrite;
    logic        w_alusrca;
    logic [1:0]  w_alusrcb;
    logic [1:0]  w_aluop;
    logic [1:0]  w_pcsrc;
    logic        w_pcen;
    logic        w_illegal;
    logic        w_retire;
    logic        w_branch_taken;

    // Branch condition: beq takes on zero; bne (when built in) on ~zero.
    // op is still valid in BRANCH because it is held until the next FETCH.
`ifdef MAIN_CTRL_BNE_EN
    assign w_branch_taken = (op == c_OP_BNE) ? ~zero : zero;
`else
    assign w_branch_taken = zero;
`endif

    // ------------------------------------------------------------------
    // State register and retired-instruction counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_retired <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_retired <= r_retired + 32'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and Moore output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next     = S_FETCH;
        w_iord     = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_regdst   = 1'b0;
        w_memtoreg = 1'b0;
        w_regwrite = 1'b0;
        w_alusrca  = 1'b0;
        w_alusrcb  = 2'b00;
        w_aluop    = 2'b00;
        w_pcsrc    = 2'b00;
        w_pcen     = 1'b0;
        w_illegal  = 1'b0;
        w_retire   = 1'b0;

        case (r_state)
            S_FETCH: begin
                // PC + 4 computed in the ALU; IR and PC load together once
                // the instruction word arrives.
                w_alusrcb = 2'b01;
                w_irwrite = mem_ready;
                w_pcen    = mem_ready;
                w_next    = mem_ready ? S_DECODE : S_FETCH;
            end

            S_DECODE: begin
                // Branch target precomputed into ALUOut.
                w_alusrcb = 2'b11;
                case (op)
                    c_OP_LW,
                    c_OP_SW:    w_next = S_MEMADR;
                    c_OP_RTYPE: w_next = S_EXECUTE;
                    c_OP_BEQ:   w_next = S_BRANCH;
`ifdef MAIN_CTRL_BNE_EN
                    c_OP_BNE:   w_next = S_BRANCH;
`endif
                    c_OP_ADDI:  w_next = S_ADDIEX;
                    c_OP_J:     w_next = S_JUMP;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end

            S_MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                w_next    = (op == c_OP_SW) ? S_MEMWR : S_MEMRD;
            end

            S_MEMRD: begin
                w_iord = 1'b1;
                w_next = mem_ready ? S_MEMWB : S_MEMRD;
            end

            S_MEMWB: begin
                w_regwrite = 1'b1;
                w_memtoreg = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end

            S_MEMWR: begin
                // Strobe held for the whole access, accepting cycle included.
                w_iord     = 1'b1;
                w_memwrite = 1'b1;
                w_retire   = mem_ready;
                w_next     = mem_ready ? S_FETCH : S_MEMWR;
            end

            S_EXECUTE: begin
                w_alusrca = 1'b1;
                w_aluop   = 2'b10;
                w_next    = S_ALUWB;
            end

            S_ALUWB: begin
                w_regwrite = 1'b1;
                w_regdst   = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end

            S_BRANCH: begin
                w_alusrca = 1'b1;
                w_aluop   = 2'b01;
                w_pcsrc   = 2'b01;
                w_pcen    = w_branch_taken;
                w_retire  = 1'b1;
                w_next    = S_FETCH;
            end

            S_ADDIEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                w_next    = S_ADDIWB;
            end

            S_ADDIWB: begin
                w_regwrite = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end

            S_JUMP: begin
                w_pcsrc  = 2'b10;
                w_pcen   = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end

            default: begin
                // Unused encodings recover to FETCH without retiring.
                w_next = S_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs. Reset already forces the state to FETCH asynchronously;
    // the architectural enables are additionally masked so nothing is
    // written while reset is held, even though FETCH gates on mem_ready.
    // ------------------------------------------------------------------
    assign iord     = w_iord;
    assign memwrite = w_memwrite & ~reset;
    assign irwrite  = w_irwrite  & ~reset;
    assign regdst   = w_regdst;
    assign memtoreg = w_memtoreg;
    assign regwrite = w_regwrite & ~reset;
    assign alusrca  = w_alusrca;
    assign alusrcb  = w_alusrcb;
    assign aluop    = w_aluop;
    assign pcsrc    = w_pcsrc;
    assign pcen     = w_pcen & ~reset;
    assign illegal  = w_illegal;
    assign retired  = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_mips_main_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_main_control
// Purpose  : Self-checking bench for mips_main_control. A table of
//            per-instruction vectors, hand-written corner sequences, and a
//            randomized run against a per-instruction step-list model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_main_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op;
    logic        zero;
    logic        mem_ready;
    logic        iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0]  alusrcb, aluop, pcsrc;
    logic        pcen, illegal;
    logic [31:0] retired;

    // Packed view of all control outputs:
    // 14 iord, 13 memwrite, 12 irwrite, 11 regdst, 10 memtoreg, 9 regwrite,
    // 8 alusrca, 7:6 alusrcb, 5:4 aluop, 3:2 pcsrc, 1 pcen, 0 illegal
    logic [14:0] outs;
    assign outs = {iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                   alusrca, alusrcb, aluop, pcsrc, pcen, illegal};

    mips_main_control dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .zero      (zero),
        .mem_ready (mem_ready),
        .iord      (iord),
        .memwrite  (memwrite),
        .irwrite   (irwrite),
        .regdst    (regdst),
        .memtoreg  (memtoreg),
        .regwrite  (regwrite),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .aluop     (aluop),
        .pcsrc     (pcsrc),
        .pcen      (pcen),
        .illegal   (illegal),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [14:0] mk(input logic io, mw, irw, rd, m2r, rw, asa,
                                        input logic [1:0] asb, aop, psrc,
                                        input logic pc, ill);
        return {io, mw, irw, rd, m2r, rw, asa, asb, aop, psrc, pc, ill};
    endfunction

    // Instruction class: 0 illegal, 1 lw, 2 sw, 3 R, 4 beq, 5 addi, 6 j, 7 bne
    function automatic int kind(input logic [5:0] o);
        case (o)
            6'b100011: return 1;
            6'b101011: return 2;
            6'b000000: return 3;
            6'b000100: return 4;
            6'b001000: return 5;
            6'b000010: return 6;
`ifdef MAIN_CTRL_BNE_EN
            6'b000101: return 7;
`endif
            default:   return 0;
        endcase
    endfunction

    // ---------------- step-list reference model ----------------
    typedef struct {
        logic [14:0] o;
        bit          wait_rdy;  // step repeats while mem_ready is low
        bit          fetch;     // irwrite/pcen follow mem_ready
        bit          br;        // pcen follows branch condition
        bit          inv;       // branch condition is ~zero
    } step_t;
    step_t q[$];

    task automatic push(input logic [14:0] o, input bit w, f, b, inv);
        step_t s;
        s.o = o; s.wait_rdy = w; s.fetch = f; s.br = b; s.inv = inv;
        q.push_back(s);
    endtask

    task automatic push_instr(input int k);
        push(mk(0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0), 1, 1, 0, 0);
        push(mk(0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,(k == 0)), 0, 0, 0, 0);
        case (k)
            1: begin
                push(mk(0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0), 0, 0, 0, 0);
                push(mk(1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0), 1, 0, 0, 0);
                push(mk(0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0,0), 0, 0, 0, 0);
            end
            2: begin
                push(mk(0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0), 0, 0, 0, 0);
                push(mk(1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0), 1, 0, 0, 0);
            end
            3: begin
                push(mk(0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0), 0, 0, 0, 0);
                push(mk(0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0,0), 0, 0, 0, 0);
            end
            4, 7: push(mk(0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0,0), 0, 0, 1, (k == 7));
            5: begin
                push(mk(0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0), 0, 0, 0, 0);
                push(mk(0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0,0), 0, 0, 0, 0);
            end
            6: push(mk(0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0), 0, 0, 0, 0);
            default: ;
        endcase
    endtask

    // ---------------- directed helpers ----------------
    logic [14:0] trace [0:39];

    // Entered at a falling edge with the DUT in FETCH. Runs one instruction;
    // mem_ready is held low for the first 'lows' cycles that have iord set.
    task automatic run_op(input logic [5:0] o, input logic z, input int lows, output int cyc);
        bit done;
        done = 0;
        cyc  = 0;
        for (int b = 0; b < 40 && !done; b++) begin
            op = o; zero = z;
            if (iord && lows > 0) begin
                mem_ready = 1'b0;
                lows--;
            end else begin
                mem_ready = 1'b1;
            end
            #1;
            trace[cyc] = outs;
            cyc++;
            @(negedge clk);
            if (alusrcb == 2'b01) done = 1;
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL run_op_timeout: got no FETCH expected FETCH within 40 cycles");
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; mem_ready = 1'b1; op = 6'd0; zero = 1'b0;
        #1;
        chk("reset_outs", {17'd0, outs}, {17'd0, mk(0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0)});
        chk("reset_retired", retired, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [5:0] op;
        logic       z;
        int         cycles;
        int         ret_inc;
        int         n_ill;
        int         n_pcen;
        int         n_mw;
        int         n_rw;
    } vec_t;

    initial begin
        vec_t        vt [10];
        int          cyc, cnt, cnt2, bad;
        logic [31:0] r0;
        logic [5:0]  cur_op;
        int          cur_k;
        logic [31:0] exp_ret;
        logic [14:0] exp_o;
        step_t       s;

        vt[0] = '{6'b100011, 1'b0, 5, 1, 0, 0, 0, 1};
        vt[1] = '{6'b101011, 1'b0, 4, 1, 0, 0, 1, 0};
        vt[2] = '{6'b000000, 1'b0, 4, 1, 0, 0, 0, 1};
        vt[3] = '{6'b001000, 1'b0, 4, 1, 0, 0, 0, 1};
        vt[4] = '{6'b000100, 1'b1, 3, 1, 0, 1, 0, 0};
        vt[5] = '{6'b000100, 1'b0, 3, 1, 0, 0, 0, 0};
        vt[6] = '{6'b000010, 1'b0, 3, 1, 0, 1, 0, 0};
        vt[7] = '{6'b111111, 1'b0, 2, 0, 1, 0, 0, 0};
`ifdef MAIN_CTRL_BNE_EN
        vt[8] = '{6'b000101, 1'b0, 3, 1, 0, 1, 0, 0};
        vt[9] = '{6'b000101, 1'b1, 3, 1, 0, 0, 0, 0};
`else
        vt[8] = '{6'b000101, 1'b0, 2, 0, 1, 0, 0, 0};
        vt[9] = '{6'b000101, 1'b1, 2, 0, 1, 0, 0, 0};
`endif

        do_reset();

        // ---------------- table-driven instruction vectors ----------------
        for (int i = 0; i < 10; i++) begin
            int n_ill, n_pc, n_mw, n_rw, n_clash;
            r0 = retired;
            run_op(vt[i].op, vt[i].z, 0, cyc);
            n_ill = 0; n_pc = 0; n_mw = 0; n_rw = 0; n_clash = 0;
            for (int k = 0; k < cyc; k++) begin
                n_ill += trace[k][0];
                n_mw  += trace[k][13];
                n_rw  += trace[k][9];
                if (k > 0) n_pc += trace[k][1];
                if (trace[k][1] && (trace[k][13] || trace[k][9])) n_clash++;
            end
            chk($sformatf("vec%0d_cycles", i), cyc, vt[i].cycles);
            chk($sformatf("vec%0d_retired", i), retired - r0, vt[i].ret_inc);
            chk($sformatf("vec%0d_illegal", i), n_ill, vt[i].n_ill);
            chk($sformatf("vec%0d_pcen", i), n_pc, vt[i].n_pcen);
            chk($sformatf("vec%0d_memwrite", i), n_mw, vt[i].n_mw);
            chk($sformatf("vec%0d_regwrite", i), n_rw, vt[i].n_rw);
            chk($sformatf("vec%0d_pcen_clash", i), n_clash, 0);
        end

        // ---------------- reset mid-lw ----------------
        chk("pre_reset_retired_nonzero", (retired != 0), 1);
        op = 6'b100011; zero = 1'b0; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("midlw_in_memrd_iord", iord, 1);
        #2;
        reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("midlw_reset_pcen", pcen, 0);
        chk("midlw_reset_regwrite", regwrite, 0);
        chk("midlw_reset_irwrite", irwrite, 0);
        chk("midlw_reset_fetch_alusrcb", alusrcb, 2'b01);
        chk("midlw_reset_retired", retired, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midlw_after_fetch", alusrcb, 2'b01);
        chk("midlw_after_retired", retired, 0);
        @(negedge clk);
        // DUT took the FETCH edge with mem_ready high; resync cleanly
        do_reset();

        // ---------------- lw with two wait states ----------------
        run_op(6'b100011, 1'b0, 2, cyc);
        chk("lw_wait_cycles", cyc, 7);
        cnt = 0;
        for (int k = 0; k < cyc; k++) cnt += trace[k][9];
        chk("lw_wait_regwrite_count", cnt, 1);
        chk("lw_wait_final_rw_m2r", {trace[6][9], trace[6][10]}, 2'b11);
        chk("lw_wait_retired", retired, 1);

        // ---------------- R-type then beq ----------------
        run_op(6'b000000, 1'b0, 0, cyc);
        chk("r_exec_aluop", trace[2][5:4], 2'b10);
        chk("r_aluwb_regdst", trace[3][11], 1);
        run_op(6'b000100, 1'b1, 0, cyc);
        chk("beq_t_aluop_pcsrc_pcen", {trace[2][5:4], trace[2][3:2], trace[2][1]}, 5'b01011);
        run_op(6'b000100, 1'b0, 0, cyc);
        chk("beq_nt_pcen", trace[2][1], 0);

        // ---------------- sw and j ----------------
        r0 = retired;
        run_op(6'b101011, 1'b0, 0, cyc);
        cnt = 0; cnt2 = 0;
        for (int k = 0; k < cyc; k++) begin
            cnt  += trace[k][13];
            cnt2 += (trace[k][13] && trace[k][14]);
        end
        chk("sw_memwrite_cycles", cnt, 1);
        chk("sw_memwrite_iord", cnt2, 1);
        run_op(6'b000010, 1'b0, 0, cyc);
        chk("j_pcsrc_pcen", {trace[2][3:2], trace[2][1]}, 3'b101);
        chk("sw_j_retired", retired - r0, 2);
        run_op(6'b101011, 1'b0, 1, cyc);
        cnt = 0;
        for (int k = 0; k < cyc; k++) cnt += trace[k][13];
        chk("sw_wait_cycles", cyc, 5);
        chk("sw_wait_memwrite", cnt, 2);

        // ---------------- illegal opcode ----------------
        r0 = retired;
        run_op(6'b111111, 1'b0, 0, cyc);
        chk("ill_cycles", cyc, 2);
        chk("ill_pulse", {trace[0][0], trace[1][0]}, 2'b01);
        chk("ill_retired", retired, r0);
`ifdef MAIN_CTRL_BNE_EN
        run_op(6'b000101, 1'b0, 0, cyc);
        chk("bne_nt_zero_pcen", trace[2][1], 1);
`endif

        // ---------------- counter wrap ----------------
        mem_ready = 1'b0;
        force dut.r_retired = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.r_retired;
        #1;
        chk("wrap_preset", retired, 32'hFFFF_FFFF);
        run_op(6'b000010, 1'b0, 0, cyc);
        chk("wrap_retired", retired, 0);

        // ---------------- randomized run against step model ----------------
        do_reset();
        exp_ret = 32'd0;
        cur_op  = 6'd0;
        cur_k   = 0;
        bad     = 0;
        for (int i = 0; i < 600; i++) begin
            if (q.size() == 0) begin
                case ($urandom % 8)
                    0: cur_op = 6'b100011;
                    1: cur_op = 6'b101011;
                    2: cur_op = 6'b000000;
                    3: cur_op = 6'b000100;
                    4: cur_op = 6'b001000;
                    5: cur_op = 6'b000010;
                    6: cur_op = 6'b000101;
                    default: cur_op = 6'($urandom);
                endcase
                cur_k = kind(cur_op);
                push_instr(cur_k);
            end
            op        = cur_op;
            zero      = 1'($urandom);
            mem_ready = (($urandom % 4) != 0);
            #1;
            s = q[0];
            exp_o = s.o;
            if (s.fetch) begin
                exp_o[12] = mem_ready;
                exp_o[1]  = mem_ready;
            end
            if (s.br) exp_o[1] = s.inv ? ~zero : zero;
            if (outs !== exp_o || retired !== exp_ret) begin
                bad++;
                if (bad <= 5)
                    $display("FAIL rand_cycle%0d op=%b: got outs=%h retired=%h expected outs=%h retired=%h",
                             i, cur_op, outs, retired, exp_o, exp_ret);
            end
            if (!(s.wait_rdy && !mem_ready)) begin
                void'(q.pop_front());
                if (q.size() == 0 && cur_k != 0) exp_ret = exp_ret + 32'd1;
            end
            @(negedge clk);
        end
        checks += 600;
        errors += bad;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
